// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the multicycle RISC-V control unit:
//   - state encodings for the main control FSM (4-bit, also driven out as
//     the debug State output)
//   - the opcode constants the FSM decodes
//   - 2-bit encodings of the datapath mux selects and the ALU decoder mode
//   - a packed bundle of every control output, and an opcode classifier
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int STATE_W = 4;

   // Main FSM states
   localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
   localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
   localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
   localparam logic [STATE_W-1:0] S_MEMREAD  = 4'd3;
   localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
   localparam logic [STATE_W-1:0] S_MEMWRITE = 4'd5;
   localparam logic [STATE_W-1:0] S_EXECUTER = 4'd6;
   localparam logic [STATE_W-1:0] S_EXECUTEI = 4'd7;
   localparam logic [STATE_W-1:0] S_ALUWB    = 4'd8;
   localparam logic [STATE_W-1:0] S_BEQ      = 4'd9;
   localparam logic [STATE_W-1:0] S_JAL      = 4'd10;
   localparam logic [STATE_W-1:0] S_LUI      = 4'd11;
   localparam logic [STATE_W-1:0] S_TRAP     = 4'd12;

   // Opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ALU decoder mode
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   // Every control output of the FSM in one bundle
   typedef struct packed {
      logic       Branch;
      logic       PCUpdate;
      logic       RegWrite;
      logic       MemWrite;
      logic       IRWrite;
      logic       AdrSrc;
      logic [1:0] ResultSrc;
      logic [1:0] ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [1:0] ALUOp;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   // Instruction classes recognised in DECODE
   typedef enum logic [2:0] {
      OPC_LOAD,
      OPC_STORE,
      OPC_RTYPE,
      OPC_ITYPE,
      OPC_BRANCH,
      OPC_JAL,
      OPC_LUI,
      OPC_OTHER
   } opclass_e;

   function automatic opclass_e classify_op(input logic [6:0] op);
      case (op)
         OP_LOAD:   return OPC_LOAD;
         OP_STORE:  return OPC_STORE;
         OP_RTYPE:  return OPC_RTYPE;
         OP_ITYPE:  return OPC_ITYPE;
         OP_BRANCH: return OPC_BRANCH;
         OP_JAL:    return OPC_JAL;
         OP_LUI:    return OPC_LUI;
         default:   return OPC_OTHER;
      endcase
   endfunction

endpackage

// File: rtl/main_fsm_if.sv
// ---------------------------------------------------------------------------
// main_fsm_if
// Bundle between the main control FSM and the multicycle datapath.
//   op        : opcode field of the instruction register   (datapath -> FSM)
//   MemReady  : memory accepts/returns an access this cycle (datapath -> FSM)
//   Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc : strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp                     : 2-bit selects
//   Illegal   : sticky unimplemented-opcode flag
//   State     : current FSM state, for debug
// Modports: master = the FSM, slave = the datapath side.
// ---------------------------------------------------------------------------
interface main_fsm_if;
   import riscv_pkg::*;

   logic [6:0]         op;
   logic               MemReady;
   logic               Branch;
   logic               PCUpdate;
   logic               RegWrite;
   logic               MemWrite;
   logic               IRWrite;
   logic               AdrSrc;
   logic [1:0]         ResultSrc;
   logic [1:0]         ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ALUOp;
   logic               Illegal;
   logic [STATE_W-1:0] State;

   modport master (
      input  op, MemReady,
      output Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal, State
   );

   modport slave (
      output op, MemReady,
      input  Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal, State
   );

endinterface

// File: rtl/main_fsm.sv
// ---------------------------------------------------------------------------
// main_fsm
// Moore control FSM of a multicycle RISC-V (RV32I subset) core: fetch,
// decode, then a per-class execute path (load, store, R/I ALU ops, beq,
// jal, lui).  Unimplemented opcodes park the FSM in TRAP with a sticky
// Illegal flag until reset.
//
// Parameters
//   USE_READY : 1 = FETCH/MEMREAD/MEMWRITE stall on MemReady,
//               0 = MemReady ignored (memory always ready)
//   EN_LUI    : 1 = lui decoded, 0 = lui treated as illegal
// Ports
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : main_fsm_if.master (op/MemReady in, control outputs out)
// ---------------------------------------------------------------------------
module main_fsm
   import riscv_pkg::*;
#(
   parameter bit USE_READY = 1'b1,
   parameter bit EN_LUI    = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   main_fsm_if.master    bus
);

   logic [STATE_W-1:0] state_q, state_d;
   logic               illegal_q, illegal_d;
   logic               ready;
   ctrl_t              ctrl;

   assign ready = USE_READY ? bus.MemReady : 1'b1;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (ready) state_d = S_DECODE;
         S_DECODE: begin
            case (classify_op(bus.op))
               OPC_LOAD,
               OPC_STORE:  state_d = S_MEMADR;
               OPC_RTYPE:  state_d = S_EXECUTER;
               OPC_ITYPE:  state_d = S_EXECUTEI;
               OPC_BRANCH: state_d = S_BEQ;
               OPC_JAL:    state_d = S_JAL;
               OPC_LUI:    state_d = EN_LUI ? S_LUI : S_TRAP;
               default:    state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (ready) state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_LUI:      state_d = S_ALUWB;
         S_TRAP:     state_d = S_TRAP;
         // Unused encodings can only come from an upset; treat as a fault.
         default:    state_d = S_TRAP;
      endcase
   end

   // Illegal is set on the same edge that enters TRAP and only reset clears it.
   assign illegal_d = illegal_q | (state_d == S_TRAP);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Output decode: every field defaults to 0, states override what they use.
   always_comb begin
      ctrl = CTRL_IDLE;
      case (state_q)
         S_FETCH: begin
            ctrl.AdrSrc    = 1'b0;
            ctrl.ALUSrcA   = SRCA_PC;
            ctrl.ALUSrcB   = SRCB_FOUR;
            ctrl.ALUOp     = ALUOP_ADD;
            ctrl.ResultSrc = RES_ALURES;
            // Only latch the instruction / bump the PC when memory delivers.
            ctrl.IRWrite   = ready;
            ctrl.PCUpdate  = ready;
         end
         S_DECODE: begin
            ctrl.ALUSrcA = SRCA_OLDPC;
            ctrl.ALUSrcB = SRCB_IMM;
            ctrl.ALUOp   = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctrl.ALUSrcA = SRCA_RS1;
            ctrl.ALUSrcB = SRCB_IMM;
            ctrl.ALUOp   = ALUOP_ADD;
         end
         S_MEMREAD: begin
            ctrl.AdrSrc    = 1'b1;
            ctrl.ResultSrc = RES_ALUOUT;
         end
         S_MEMWB: begin
            ctrl.ResultSrc = RES_DATA;
            ctrl.RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.AdrSrc    = 1'b1;
            ctrl.ResultSrc = RES_ALUOUT;
            ctrl.MemWrite  = 1'b1;
         end
         S_EXECUTER: begin
            ctrl.ALUSrcA = SRCA_RS1;
            ctrl.ALUSrcB = SRCB_RS2;
            ctrl.ALUOp   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ctrl.ALUSrcA = SRCA_RS1;
            ctrl.ALUSrcB = SRCB_IMM;
            ctrl.ALUOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.ResultSrc = RES_ALUOUT;
            ctrl.RegWrite  = 1'b1;
         end
         S_BEQ: begin
            ctrl.ALUSrcA   = SRCA_RS1;
            ctrl.ALUSrcB   = SRCB_RS2;
            ctrl.ALUOp     = ALUOP_SUB;
            ctrl.ResultSrc = RES_ALUOUT;
            ctrl.Branch    = 1'b1;
         end
         S_JAL: begin
            ctrl.ALUSrcA   = SRCA_OLDPC;
            ctrl.ALUSrcB   = SRCB_FOUR;
            ctrl.ALUOp     = ALUOP_ADD;
            ctrl.ResultSrc = RES_ALUOUT;
            ctrl.PCUpdate  = 1'b1;
         end
         S_LUI: begin
            // rd = 0 + imm: operand A forced to zero.
            ctrl.ALUSrcA = SRCA_ZERO;
            ctrl.ALUSrcB = SRCB_IMM;
            ctrl.ALUOp   = ALUOP_ADD;
         end
         default: ctrl = CTRL_IDLE;
      endcase
   end

   assign bus.Branch    = ctrl.Branch;
   assign bus.PCUpdate  = ctrl.PCUpdate;
   assign bus.RegWrite  = ctrl.RegWrite;
   assign bus.MemWrite  = ctrl.MemWrite;
   assign bus.IRWrite   = ctrl.IRWrite;
   assign bus.AdrSrc    = ctrl.AdrSrc;
   assign bus.ResultSrc = ctrl.ResultSrc;
   assign bus.ALUSrcA   = ctrl.ALUSrcA;
   assign bus.ALUSrcB   = ctrl.ALUSrcB;
   assign bus.ALUOp     = ctrl.ALUOp;
   assign bus.Illegal   = illegal_q;
   assign bus.State     = state_q;

endmodule
